dm_responder: RTL

- Data-memory responder: the slave end of the control bus's data-memory strobes (RD_EN_DM / WR_EN_DM).
- Accepts one read or write per request, models a synchronous data memory with configurable access latency, and returns read data plus a one-cycle DONE pulse.
- Sits between the control bus and the datapath; holds the 19-bit data array internally.

---
 rtl/dm_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one read or write per request on the control bus
// strobes, models a fixed-latency synchronous memory and returns data with a DONE pulse.
module dm_responder #(
    parameter int DATA_W  = 19,
    parameter int ADDR_W  = 19,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              RD_EN_DM,
    input  logic              WR_EN_DM,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              OVERRUN
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W    = 4;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rej_q, rej_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              overrun_q, overrun_d;
    logic              req_s;
    logic              mem_we_s;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign req_s = RD_EN_DM | WR_EN_DM;

    // Next-state, request capture and commit decisions
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        rej_d     = rej_q;
        rdata_d   = rdata_q;
        overrun_d = overrun_q;
        mem_we_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req_s) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                    addr_d  = ADDR[IDX_W-1:0];
                    wdata_d = WDATA;
                    wr_d    = WR_EN_DM;
                    // Full-width compare: high address bits are never discarded
                    rej_d   = (RD_EN_DM & WR_EN_DM) | ({1'b0, ADDR} >= DEPTH_C);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (req_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_RESP;
                    if (rej_q) begin
                        mem_we_s = 1'b0;
                    end else if (wr_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ACCESS);
        done_d = (state_d == ST_RESP);
        err_d  = done_d & rej_q;
    end

    // Control state and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            addr_q    <= {IDX_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wr_q      <= 1'b0;
            rej_q     <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rej_q     <= rej_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; deliberately left out of reset so contents survive it
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign RDATA   = rdata_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign OVERRUN = overrun_q;

endmodule
